// File: rtl/out_channel_checker.sv
`default_nettype none
// ============================================================================
//  Module   : out_channel_checker
//  Purpose  : Consumes a program's out channel over valid/ready and compares
//             each accepted word, in order, against a parameterised expected
//             sequence. Reports PASS once the producer signals completion, or
//             FAIL with an error code on the first problem seen.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock           in   1      single clock, all state changes on posedge
//    reset           in   1      synchronous, active-high
//    start           in   1      begin a check (ignored while running)
//    in_valid        in   1      producer has a word on in_data
//    in_data         in   WIDTH  word from the out channel
//    in_ready        out  1      high exactly while a check is running
//    producer_done   in   1      producer has emitted its last word (level)
//    finished        out  1      check complete (pass or fail)
//    success         out  1      high only after a passing check
//    error_code      out  3      0 none, 1 mismatch, 2 overflow, 3 underflow,
//                                4 timeout
//    fail_index      out  5      index of first bad word, 5'h1F if none
//    fail_data       out  WIDTH  word captured on mismatch/overflow, else 0
//    received_count  out  5      words accepted in this check
//  Configuration
//    CHECK_TIMEOUT_EN : when defined, a watchdog fails a check that has been
//                       running for MAX_STEPS cycles without a decision.
// ============================================================================
module out_channel_checker #(
  parameter int                        WIDTH     = 12,
  parameter int                        DEPTH     = 4,
  parameter logic [DEPTH*WIDTH-1:0]    EXPECTED  = 48'h00B_009_007_005,
  parameter int                        MAX_STEPS = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             producer_done,
  output logic             finished,
  output logic             success,
  output logic [2:0]       error_code,
  output logic [4:0]       fail_index,
  output logic [WIDTH-1:0] fail_data,
  output logic [4:0]       received_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [4:0] C_DEPTH     = 5'(DEPTH);
  localparam logic [4:0] C_COUNT_MAX = 5'(DEPTH + 1);
  localparam logic [4:0] C_NO_INDEX  = 5'h1F;

  localparam logic [2:0] C_ERR_NONE     = 3'd0;
  localparam logic [2:0] C_ERR_MISMATCH = 3'd1;
  localparam logic [2:0] C_ERR_OVERFLOW = 3'd2;
  localparam logic [2:0] C_ERR_UNDERFLOW= 3'd3;

  state_t             r_state,    w_state_nxt;
  logic               r_ready;
  logic               r_finished, w_finished_nxt;
  logic               r_success,  w_success_nxt;
  logic [2:0]         r_err,      w_err_nxt;
  logic [4:0]         r_fidx,     w_fidx_nxt;
  logic [WIDTH-1:0]   r_fdata,    w_fdata_nxt;
  logic [4:0]         r_count,    w_count_nxt;

  logic [WIDTH-1:0]   w_exp_word;
  logic [4:0]         w_count_upd;
  logic               w_decided;
  logic               w_xfer;

`ifdef CHECK_TIMEOUT_EN
  localparam int               WDW          = $clog2(MAX_STEPS + 1);
  localparam logic [WDW-1:0]   C_WD_LAST    = WDW'(MAX_STEPS - 1);
  localparam logic [2:0]       C_ERR_TIMEOUT= 3'd4;
  logic [WDW-1:0]              r_wdog, w_wdog_nxt;
`endif

  // Expected word for the current position; zero once the sequence is
  // exhausted (that word is never compared, overflow is reported instead).
  always_comb begin
    w_exp_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_count == 5'(k)) begin
        w_exp_word = EXPECTED[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer = in_valid && r_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_finished_nxt = r_finished;
    w_success_nxt  = r_success;
    w_err_nxt      = r_err;
    w_fidx_nxt     = r_fidx;
    w_fdata_nxt    = r_fdata;
    w_count_nxt    = r_count;
    w_count_upd    = r_count;
    w_decided      = 1'b0;
`ifdef CHECK_TIMEOUT_EN
    w_wdog_nxt     = r_wdog;
`endif

    case (r_state)
      S_RUN: begin
        // Transfer outcome first; a transfer error outranks producer_done.
        if (w_xfer) begin
          if (r_count < C_DEPTH) begin
            if (in_data == w_exp_word) begin
              w_count_upd = r_count + 5'd1;
            end else begin
              w_decided      = 1'b1;
              w_state_nxt    = S_FAIL;
              w_err_nxt      = C_ERR_MISMATCH;
              w_fidx_nxt     = r_count;
              w_fdata_nxt    = in_data;
            end
          end else begin
            // Extra word beyond the expected sequence still counts as received.
            if (r_count != C_COUNT_MAX) begin
              w_count_upd = r_count + 5'd1;
            end
            w_decided      = 1'b1;
            w_state_nxt    = S_FAIL;
            w_err_nxt      = C_ERR_OVERFLOW;
            w_fidx_nxt     = C_DEPTH;
            w_fdata_nxt    = in_data;
          end
        end
        w_count_nxt = w_count_upd;

        // Completion judged against the count including this cycle's word.
        if (!w_decided && producer_done) begin
          w_decided = 1'b1;
          if (w_count_upd == C_DEPTH) begin
            w_state_nxt = S_PASS;
          end else begin
            w_state_nxt = S_FAIL;
            w_err_nxt   = C_ERR_UNDERFLOW;
            w_fidx_nxt  = w_count_upd;
          end
        end

`ifdef CHECK_TIMEOUT_EN
        if (!w_decided) begin
          if (r_wdog == C_WD_LAST) begin
            w_decided   = 1'b1;
            w_state_nxt = S_FAIL;
            w_err_nxt   = C_ERR_TIMEOUT;
            w_fidx_nxt  = w_count_upd;
          end else begin
            w_wdog_nxt  = r_wdog + 1'b1;
          end
        end
`endif

        if (w_decided) begin
          w_finished_nxt = 1'b1;
          w_success_nxt  = (w_state_nxt == S_PASS);
        end
      end

      default: begin
        // IDLE, PASS and FAIL all accept start and clear the check state.
        if (start) begin
          w_state_nxt    = S_RUN;
          w_finished_nxt = 1'b0;
          w_success_nxt  = 1'b0;
          w_err_nxt      = C_ERR_NONE;
          w_fidx_nxt     = C_NO_INDEX;
          w_fdata_nxt    = '0;
          w_count_nxt    = '0;
`ifdef CHECK_TIMEOUT_EN
          w_wdog_nxt     = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_finished <= 1'b0;
      r_success  <= 1'b0;
      r_err      <= C_ERR_NONE;
      r_fidx     <= C_NO_INDEX;
      r_fdata    <= '0;
      r_count    <= '0;
`ifdef CHECK_TIMEOUT_EN
      r_wdog     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      // Registered copy of "next state is RUN" so in_ready tracks RUN exactly.
      r_ready    <= (w_state_nxt == S_RUN);
      r_finished <= w_finished_nxt;
      r_success  <= w_success_nxt;
      r_err      <= w_err_nxt;
      r_fidx     <= w_fidx_nxt;
      r_fdata    <= w_fdata_nxt;
      r_count    <= w_count_nxt;
`ifdef CHECK_TIMEOUT_EN
      r_wdog     <= w_wdog_nxt;
`endif
    end
  end

  assign in_ready       = r_ready;
  assign finished       = r_finished;
  assign success        = r_success;
  assign error_code     = r_err;
  assign fail_index     = r_fidx;
  assign fail_data      = r_fdata;
  assign received_count = r_count;

endmodule
`default_nettype wire
